// File: rtl/matmul_pkg.sv
// Shared types and helpers for the pipelined matrix-multiply engine.
package matmul_pkg;

    localparam int unsigned MAX_MEM_LAT = 4;
    localparam int unsigned TAG_DIM_W   = 16;   // must be >= DIM_W of the engine
    localparam int unsigned SAT_W       = 128;  // must be >= ACC_W of the engine

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [TAG_DIM_W-1:0] i;
        logic [TAG_DIM_W-1:0] j;
    } tag_t;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [SAT_W-1:0] sat_clip(input logic signed [SAT_W-1:0] v,
                                                         input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        lo = ~hi;
        r  = v;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate with saturating/truncating and ReLU write-back stage.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              valid_i,
    input  logic              first_i,
    input  logic              last_i,
    input  logic              sat_en_i,
    input  logic              relu_en_i,
    output logic [DATA_W-1:0] data_o,
    output logic              we_o
);

    logic signed [2*DATA_W-1:0] mul;
    logic signed [ACC_W-1:0]    prod;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    acc_q;
    logic [DATA_W-1:0]          res;
    logic [DATA_W-1:0]          data_q;
    logic                       we_q;

    always_comb begin
        mul  = (2*DATA_W)'($signed(a_i)) * (2*DATA_W)'($signed(b_i));
        prod = ACC_W'(mul);
        sum  = first_i ? prod : acc_q + prod;
        if (sat_en_i) begin
            res = DATA_W'(sat_clip(SAT_W'(sum), DATA_W));
        end else begin
            res = sum[DATA_W-1:0];
        end
        if (relu_en_i && res[DATA_W-1]) begin
            res = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
        end else begin
            we_q <= valid_i && last_i;
            if (valid_i) begin
                acc_q <= sum;
            end
            if (valid_i && last_i) begin
                data_q <= res;
            end
        end
    end

    assign data_o = data_q;
    assign we_o   = we_q;

endmodule

// File: rtl/matmul_engine.sv
// C = A*B engine: issue FSM, strided address counters and a tag pipeline matching memory latency.
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ACC_W   = 64,
    parameter int unsigned DIM_W   = 10,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  m,
    input  logic [DIM_W-1:0]  n,
    input  logic [DIM_W-1:0]  k,
    input  logic [ADDR_W-1:0] input_base,
    input  logic [ADDR_W-1:0] weight_base,
    input  logic [ADDR_W-1:0] output_base,
    input  logic              sat_en,
    input  logic              relu_en,
    output logic [ADDR_W-1:0] input_addr,
    output logic [ADDR_W-1:0] weight_addr,
    input  logic [DATA_W-1:0] input_data,
    input  logic [DATA_W-1:0] weight_data,
    output logic [ADDR_W-1:0] output_addr,
    output logic [DATA_W-1:0] output_data,
    output logic              write_enable,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_e state_q, state_d;

    logic [DIM_W-1:0]  m_q, n_q, k_q, p_q, j_q, i_q;
    logic [DIM_W-1:0]  p_nx, j_nx, i_nx;
    logic [ADDR_W-1:0] in_addr_q, in_row_q, wt_addr_q, wt_col_q, wt_base_q;
    logic [ADDR_W-1:0] in_nx, in_row_nx, wt_nx, wt_col_nx;
    logic [ADDR_W-1:0] out_row_q, out_addr_q;
    logic              sat_q, relu_q, err_q, fin_q;
    logic              zero_dim, last_p, last_j, last_i, final_pair, tag_final;
    tag_t              tag_q [MEM_LAT+1];
    tag_t              tag_out, start_tag, issue_tag;

    assign zero_dim = (m == '0) || (n == '0) || (k == '0);

    // Strides replace i*k+p and p*n+j: row/column anchors are bumped as the counters wrap.
    always_comb begin
        last_p     = (p_q == k_q - 1'b1);
        last_j     = (j_q == n_q - 1'b1);
        last_i     = (i_q == m_q - 1'b1);
        final_pair = last_p && last_j && last_i;
        p_nx       = p_q + 1'b1;
        j_nx       = j_q;
        i_nx       = i_q;
        in_nx      = in_addr_q + 1'b1;
        wt_nx      = wt_addr_q + ADDR_W'(n_q);
        in_row_nx  = in_row_q;
        wt_col_nx  = wt_col_q;
        if (last_p) begin
            p_nx = '0;
            if (last_j) begin
                j_nx      = '0;
                i_nx      = i_q + 1'b1;
                in_row_nx = in_row_q + ADDR_W'(k_q);
                wt_col_nx = wt_base_q;
            end else begin
                j_nx      = j_q + 1'b1;
                wt_col_nx = wt_col_q + 1'b1;
            end
            in_nx = in_row_nx;
            wt_nx = wt_col_nx;
        end
        issue_tag       = '0;
        issue_tag.valid = 1'b1;
        issue_tag.first = (p_nx == '0);
        issue_tag.last  = (p_nx == k_q - 1'b1);
        issue_tag.i     = TAG_DIM_W'(i_nx);
        issue_tag.j     = TAG_DIM_W'(j_nx);
        start_tag       = '0;
        start_tag.valid = 1'b1;
        start_tag.first = 1'b1;
        start_tag.last  = (k == DIM_W'(1));
        tag_out         = tag_q[MEM_LAT];
        tag_final       = tag_out.valid && tag_out.last
                          && (tag_out.i == TAG_DIM_W'(m_q - 1'b1))
                          && (tag_out.j == TAG_DIM_W'(n_q - 1'b1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = zero_dim ? FINISH : ISSUE;
            ISSUE:   if (final_pair) state_d = DRAIN;
            DRAIN:   if (fin_q) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {m_q, n_q, k_q, p_q, j_q, i_q} <= '0;
            {in_addr_q, in_row_q, wt_addr_q, wt_col_q, wt_base_q} <= '0;
            {out_row_q, out_addr_q} <= '0;
            {sat_q, relu_q, err_q, fin_q} <= '0;
            for (int unsigned s = 0; s <= MEM_LAT; s++) tag_q[s] <= '0;
        end else begin
            err_q    <= (state_q == IDLE) && start && zero_dim;
            fin_q    <= tag_final;
            tag_q[0] <= '0;
            for (int unsigned s = 1; s <= MEM_LAT; s++) tag_q[s] <= tag_q[s-1];
            // Writes leave in row-major order, so the output address advances by row anchor + j.
            if (tag_out.valid && tag_out.last) begin
                out_addr_q <= out_row_q + ADDR_W'(tag_out.j);
                if (tag_out.j == TAG_DIM_W'(n_q - 1'b1)) out_row_q <= out_row_q + ADDR_W'(n_q);
            end
            case (state_q)
                IDLE: if (start && !zero_dim) begin
                    {m_q, n_q, k_q} <= {m, n, k};
                    {p_q, j_q, i_q} <= '0;
                    {sat_q, relu_q} <= {sat_en, relu_en};
                    in_addr_q <= input_base;
                    in_row_q  <= input_base;
                    wt_addr_q <= weight_base;
                    wt_col_q  <= weight_base;
                    wt_base_q <= weight_base;
                    out_row_q <= output_base;
                    tag_q[0]  <= start_tag;
                end
                ISSUE: if (!final_pair) begin
                    {p_q, j_q, i_q} <= {p_nx, j_nx, i_nx};
                    in_addr_q <= in_nx;
                    in_row_q  <= in_row_nx;
                    wt_addr_q <= wt_nx;
                    wt_col_q  <= wt_col_nx;
                    tag_q[0]  <= issue_tag;
                end
                default: ;
            endcase
        end
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_i       (input_data),
        .b_i       (weight_data),
        .valid_i   (tag_out.valid),
        .first_i   (tag_out.first),
        .last_i    (tag_out.last),
        .sat_en_i  (sat_q),
        .relu_en_i (relu_q),
        .data_o    (output_data),
        .we_o      (write_enable)
    );

    assign input_addr  = in_addr_q;
    assign weight_addr = wt_addr_q;
    assign output_addr = out_addr_q;
    assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
    assign done        = (state_q == FINISH);
    assign error       = err_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed + randomized jobs on a 32-bit/latency-1 engine and an 8-bit/latency-3 engine.
module tb_matmul_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sel = 1'b0;
    logic [9:0]  m = '0, n = '0, k = '0;
    logic [15:0] ib = '0, wb = '0, ob = '0;
    logic sat_en = 1'b0, relu_en = 1'b0;

    logic [15:0] a_in_addr, a_wt_addr, a_out_addr, b_in_addr, b_wt_addr, b_out_addr;
    logic [31:0] a_in_data, a_wt_data, a_out_data;
    logic [7:0]  b_in_data, b_wt_data, b_out_data;
    logic a_we, a_busy, a_done, a_err, b_we, b_busy, b_done, b_err;

    logic [31:0] mem_in [65536];
    logic [31:0] mem_wt [65536];
    logic [31:0] pa_in [4], pa_wt [4], pb_in [4], pb_wt [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    matmul_engine #(.DATA_W(32), .ACC_W(64), .DIM_W(10), .ADDR_W(16), .MEM_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .m(m), .n(n), .k(k),
        .input_base(ib), .weight_base(wb), .output_base(ob), .sat_en(sat_en), .relu_en(relu_en),
        .input_addr(a_in_addr), .weight_addr(a_wt_addr), .input_data(a_in_data), .weight_data(a_wt_data),
        .output_addr(a_out_addr), .output_data(a_out_data), .write_enable(a_we),
        .busy(a_busy), .done(a_done), .error(a_err));

    matmul_engine #(.DATA_W(8), .ACC_W(24), .DIM_W(10), .ADDR_W(16), .MEM_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .m(m), .n(n), .k(k),
        .input_base(ib), .weight_base(wb), .output_base(ob), .sat_en(sat_en), .relu_en(relu_en),
        .input_addr(b_in_addr), .weight_addr(b_wt_addr), .input_data(b_in_data), .weight_data(b_wt_data),
        .output_addr(b_out_addr), .output_data(b_out_data), .write_enable(b_we),
        .busy(b_busy), .done(b_done), .error(b_err));

    // Synchronous-read memories: data appears MEM_LAT cycles after the address.
    always @(posedge clk) begin
        pa_in[0] <= mem_in[a_in_addr];
        pa_wt[0] <= mem_wt[a_wt_addr];
        pb_in[0] <= mem_in[b_in_addr];
        pb_wt[0] <= mem_wt[b_wt_addr];
        for (int s = 1; s < 4; s++) begin
            pa_in[s] <= pa_in[s-1];
            pa_wt[s] <= pa_wt[s-1];
            pb_in[s] <= pb_in[s-1];
            pb_wt[s] <= pb_wt[s-1];
        end
    end
    assign a_in_data = pa_in[0];
    assign a_wt_data = pa_wt[0];
    assign b_in_data = pb_in[2][7:0];
    assign b_wt_data = pb_wt[2][7:0];

    logic [15:0] o_in_addr, o_wt_addr, o_out_addr;
    logic [31:0] o_wdata;
    logic o_we, o_busy, o_done, o_err;
    assign o_in_addr  = sel ? b_in_addr : a_in_addr;
    assign o_wt_addr  = sel ? b_wt_addr : a_wt_addr;
    assign o_out_addr = sel ? b_out_addr : a_out_addr;
    assign o_wdata    = sel ? {24'h0, b_out_data} : a_out_data;
    assign o_we       = sel ? b_we : a_we;
    assign o_busy     = sel ? b_busy : a_busy;
    assign o_done     = sel ? b_done : a_done;
    assign o_err      = sel ? b_err : a_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [31:0] v, input int w);
        if (w == 8) return longint'($signed(v[7:0]));
        return longint'($signed(v));
    endfunction

    // Reference: plain dot product, then clamp/truncate to w bits, then ReLU.
    function automatic logic [31:0] ref_elem(input int e, input int nn, input int kk, input int ibv,
                                             input int wbv, input int w, input bit sat, input bit relu);
        longint acc = 0;
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -hi - 1;
        logic [31:0] r;
        int i = e / nn;
        int j = e % nn;
        for (int p = 0; p < kk; p++)
            acc += sx(mem_in[(ibv + i*kk + p) & 16'hFFFF], w) * sx(mem_wt[(wbv + p*nn + j) & 16'hFFFF], w);
        if (sat) begin
            if (acc > hi) acc = hi;
            else if (acc < lo) acc = lo;
        end
        r = 32'(acc);
        if (w == 8) r = {24'h0, r[7:0]};
        if (relu && r[w-1]) r = '0;
        return r;
    endfunction

    task automatic fill(input bit to_wt, input int base, input int cnt);
        for (int q = 0; q < cnt; q++) begin
            if (to_wt) mem_wt[(base + q) & 16'hFFFF] = $urandom;
            else       mem_in[(base + q) & 16'hFFFF] = $urandom;
        end
    endtask

    task automatic run_job(input bit s, input int mm, input int nn, input int kk, input int ibv,
                           input int wbv, input int obv, input bit sat, input bit relu, input bit poke);
        int lat = s ? 3 : 1;
        int w = s ? 8 : 32;
        int total = mm * nn * kk;
        bit zero = (mm == 0) || (nn == 0) || (kk == 0);
        int limit = total + lat + 12;
        int wcnt = 0;
        bit seen_done = 1'b0;
        logic [31:0] expv [$];
        if (!zero) for (int e = 0; e < mm*nn; e++) expv.push_back(ref_elem(e, nn, kk, ibv, wbv, w, sat, relu));
        @(negedge clk);
        sel = s; m = 10'(mm); n = 10'(nn); k = 10'(kk);
        ib = 16'(ibv); wb = 16'(wbv); ob = 16'(obv); sat_en = sat; relu_en = relu; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m = 10'($urandom); n = 10'($urandom); k = 10'($urandom);
        ib = 16'($urandom); wb = 16'($urandom); ob = 16'($urandom);
        sat_en = ~sat; relu_en = ~relu;
        for (int x = 1; x <= limit && !seen_done; x++) begin
            @(negedge clk);
            if (poke && x == 3) start = 1'b1;
            if (poke && x == 4) start = 1'b0;
            if (!zero && x <= total) begin
                int t = x - 1;
                int p = t % kk;
                int j = (t / kk) % nn;
                int i = t / (kk * nn);
                chk("input_addr", o_in_addr, (ibv + i*kk + p) & 16'hFFFF);
                chk("weight_addr", o_wt_addr, (wbv + p*nn + j) & 16'hFFFF);
            end
            chk("busy", o_busy, !zero && (x <= total + lat + 1));
            if (o_we) begin
                chk("write_in_range", wcnt < expv.size(), 1);
                if (wcnt < expv.size()) begin
                    chk("output_addr", o_out_addr, (obv + wcnt) & 16'hFFFF);
                    chk("output_data", o_wdata, expv[wcnt]);
                    chk("write_cycle", x, (wcnt + 1) * kk + lat + 1);
                end
                wcnt++;
            end
            if (o_done) begin
                seen_done = 1'b1;
                chk("done_cycle", x, zero ? 1 : total + lat + 2);
                chk("error", o_err, zero);
                chk("write_count", wcnt, expv.size());
            end else begin
                chk("error_idle", o_err, 0);
            end
        end
        chk("done_seen", seen_done, 1);
    endtask

    task automatic chk_outputs_zero(input string when);
        chk({when, "_a_addrs"}, {a_in_addr, a_wt_addr, a_out_addr}, 0);
        chk({when, "_a_data"}, a_out_data, 0);
        chk({when, "_a_flags"}, {a_we, a_busy, a_done, a_err}, 0);
        chk({when, "_b_addrs"}, {b_in_addr, b_wt_addr, b_out_addr}, 0);
        chk({when, "_b_data"}, b_out_data, 0);
        chk({when, "_b_flags"}, {b_we, b_busy, b_done, b_err}, 0);
    endtask

    initial begin
        int quiet_bad;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        mem_in[0] = 1; mem_in[1] = 2; mem_in[2] = 3; mem_in[3] = 4;
        mem_wt[0] = 5; mem_wt[1] = 6; mem_wt[2] = 7; mem_wt[3] = 8;
        run_job(0, 2, 2, 2, 0, 0, 0, 0, 0, 0);

        mem_in[16'h10] = -32'sd3; mem_in[16'h11] = 32'sd4;
        mem_wt[16'h20] = 32'sd5;  mem_wt[16'h21] = -32'sd6;
        run_job(0, 1, 1, 2, 16'h10, 16'h20, 16'h30, 0, 0, 0);
        run_job(0, 1, 1, 2, 16'h10, 16'h20, 16'h30, 0, 1, 0);

        mem_in[16'h40] = 100; mem_in[16'h41] = 100;
        mem_wt[16'h50] = 100; mem_wt[16'h51] = 100;
        run_job(1, 1, 1, 2, 16'h40, 16'h50, 16'h60, 1, 0, 0);
        run_job(1, 1, 1, 2, 16'h40, 16'h50, 16'h60, 0, 0, 0);

        fill(0, 16'h100, 12);
        fill(1, 16'h200, 4);
        run_job(1, 3, 1, 4, 16'h100, 16'h200, 16'h300, 0, 0, 0);

        run_job(0, 2, 3, 0, 0, 0, 0, 0, 0, 0);
        run_job(1, 0, 2, 2, 0, 0, 0, 0, 0, 0);

        for (int r = 0; r < 10; r++) begin
            int mm = $urandom_range(1, 4);
            int nn = $urandom_range(1, 4);
            int kk = (r == 4 || r == 5) ? 1 : $urandom_range(1, 4);
            int ibv = $urandom_range(0, 65535);
            int wbv = $urandom_range(0, 65535);
            int obv = $urandom_range(0, 65535);
            fill(0, ibv, mm * kk);
            fill(1, wbv, kk * nn);
            run_job(r[0], mm, nn, kk, ibv, wbv, obv, 1'($urandom), 1'($urandom), 0);
        end

        fill(0, 0, 16);
        fill(1, 0, 16);
        @(negedge clk);
        sel = 1'b0; m = 10'd4; n = 10'd4; k = 10'd4; ib = '0; wb = '0; ob = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_before_reset", a_busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        quiet_bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (a_we || a_busy || a_done) quiet_bad++;
        end
        chk("quiet_after_reset", quiet_bad, 0);

        fill(0, 16'h0800, 16);
        fill(1, 16'h0900, 16);
        run_job(0, 4, 4, 4, 16'h0800, 16'h0900, 16'h0A00, 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised, pipelined successor to the team's single-cycle-read matrix multiplier. It computes C = A·B for an m×k input matrix A and a k×n weight matrix B, both row-major in external synchronous-read memories, and writes the m×n result row-major to an output memory. It sustains one multiply-accumulate (MAC) per cycle across element boundaries, tolerates configurable memory read latency and relocatable base addresses, and adds signed saturation and ReLU output modes. It sits between the layer sequencer and the activation/weight RAMs of the NN datapath.

## Interface
- DATA_W, 32: operand and result width, signed two's complement.
- ACC_W, 64: accumulator width; must be ≥ 2·DATA_W.
- DIM_W, 10: width of the m, n and k fields.
- ADDR_W, 16: memory address width.
- MEM_LAT, 1: read latency in cycles, address to data; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin job; sampled only in IDLE.
- m, n, k  in  DIM_W each  dimensions; latched when start is accepted.
- input_base, weight_base, output_base  in  ADDR_W each  base addresses; latched when start is accepted.
- sat_en  in  1  1: saturate the result to DATA_W; 0: truncate to the low DATA_W bits. Latched at start.
- relu_en  in  1  1: clamp negative results to 0. Latched at start.
- input_addr, weight_addr  out  ADDR_W each  registered read addresses.
- input_data, weight_data  in  DATA_W each  read data, valid MEM_LAT cycles after the address.
- output_addr  out  ADDR_W  write address.
- output_data  out  DATA_W  write data.
- write_enable  out  1  one-cycle write strobe.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at job end.
- error  out  1  one-cycle pulse, coincident with done, when a zero dimension is given.

## Operation
- Reset values: every output is 0; the FSM is in IDLE; the valid pipeline is cleared.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE → ISSUE on start when m, n and k are all non-zero.
  - IDLE → FINISH on start when any of m, n, k is 0. No reads or writes occur, and error is pulsed.
  - ISSUE → DRAIN after the final address pair is issued.
  - DRAIN → FINISH when the last write has been emitted.
  - FINISH → IDLE unconditionally.
- Issue loop: counters p (inner), j, i. Exactly one address pair is issued per ISSUE cycle, with no gap between output elements.
  - input_addr = input_base + i·k + p.
  - weight_addr = weight_base + p·n + j.
  - Both wrap modulo 2^ADDR_W.
- Tag pipeline: each issued pair carries {valid, first, last, i, j} tags through a MEM_LAT-deep shift register.
- Accumulation: a product is formed as a signed DATA_W×DATA_W multiply, sign-extended to ACC_W.
  - A tag with first set loads the product into the accumulator.
  - Any other valid tag adds the product to the accumulator.
- Write-back: a tag with last set registers output_addr = output_base + i·n + j, output_data = post-processed (acc + product), and write_enable = 1 in the following cycle.
- Post-processing order:
  1. Saturate (if sat_en) to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; otherwise truncate.
  2. Apply ReLU (if relu_en).
- k = 1: every tag is both first and last, so one write is produced per cycle.
- start while busy is ignored. Input changes after acceptance have no effect.
- Reset mid-job returns the block to IDLE immediately. In-flight data is discarded and no further writes occur.

## Timing
- Start is accepted at edge T, and total = m·n·k.
- Addresses are valid in cycles T+1 … T+total.
- The write for element e (0-based, row-major) occurs in cycle T + (e+1)·k + MEM_LAT + 1.
- done occurs in cycle T + total + MEM_LAT + 2; busy falls in the same cycle.
- A zero-dimension start produces done and error in cycle T+1.
- A new start may be accepted in the cycle after done.

## Structure
- Package matmul_pkg holds:
  - the state enum;
  - the tag struct {valid, first, last, i, j};
  - MAX_MEM_LAT = 4;
  - the saturation helper function.
- Sub-module matmul_mac holds the multiplier, accumulator, saturation and ReLU stage (one registered output).
- The top level holds the FSM, the address counters and the tag pipeline.
- Addresses are generated by incremental adders (row/column strides), not by runtime multipliers.

## Test plan
- 2×2×2, MEM_LAT=1, A=[[1,2],[3,4]], B=[[5,6],[7,8]] → writes 19, 22, 43, 50 at addresses 0..3; done at T+11.
- Signed 1×1×2, A=[−3,4], B=[5,−6], relu_en=0 → −39; same job with relu_en=1 → 0.
- DATA_W=8, sat_en=1, A=[100,100], B=[100,100] → 127; sat_en=0 → low byte of 20000 (0x20).
- MEM_LAT=3, 3×1×4 (k=4, n=1), bases 0x100/0x200/0x300 → 3 writes at 0x300..0x302 spaced 4 cycles apart; no address gaps during ISSUE.
- k=0 start → done and error at T+1; no write_enable; busy never high.
- Assert rst_n low mid-ISSUE of a 4×4×4 job → all outputs 0 immediately, no write after release; a subsequent start runs correctly; start pulsed while busy is ignored.
